// File: rtl/tremolo_ctrl.sv
// tremolo_ctrl: footswitch debounce/toggle and slew-limited level/frequency front end for the tremolo core
//   clk_i               system clock
//   rstn_i              asynchronous active-low reset
//   sample_tick_i       one-clock strobe per audio sample; paces all timing
//   footswitch_i        raw asynchronous footswitch, 1 = pressed
//   level_raw_i         target modulation depth code
//   frequency_raw_i     target frequency table index
//   enable_o            effect enable to the core
//   level_o             slewed depth to the core
//   frequency_number_o  slewed frequency index to the core
// Optional feature: define TREMOLO_CTRL_FADE_EN for fade-in/fade-out switching;
// otherwise the press flips enable_o directly and level_o always tracks its target.
module tremolo_ctrl #(
    parameter int unsigned DEBOUNCE_TICKS = 480,
    parameter int unsigned SLEW_DIV       = 4
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       sample_tick_i,
    input  logic       footswitch_i,
    input  logic [7:0] level_raw_i,
    input  logic [7:0] frequency_raw_i,
    output logic       enable_o,
    output logic [7:0] level_o,
    output logic [7:0] frequency_number_o
);
    typedef enum logic [1:0] {BYPASS, FADE_IN, ACTIVE, FADE_OUT} state_t;
    state_t      state, state_nxt;
    logic        fs_meta, fs_sync, fs_db, fs_db_d, toggle, slew_ev;
    logic [15:0] db_cnt;
    logic [7:0]  div, lvl_tgt, frq_tgt, lvl_goal;
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        return (cur < tgt) ? cur + 8'd1 : (cur > tgt) ? cur - 8'd1 : cur;
    endfunction
    // press edge of the debounced switch; high the clock after the accepting tick
    assign toggle  = fs_db & ~fs_db_d;
    assign slew_ev = sample_tick_i && (div == 8'(SLEW_DIV - 1));
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fs_meta <= 1'b0;
            fs_sync <= 1'b0;
            fs_db   <= 1'b0;
            fs_db_d <= 1'b0;
            db_cnt  <= '0;
        end else begin
            fs_meta <= footswitch_i;
            fs_sync <= fs_meta;
            fs_db_d <= fs_db;
            if (sample_tick_i) begin
                if (fs_sync != fs_db) begin
                    if (db_cnt == 16'(DEBOUNCE_TICKS - 1)) begin
                        fs_db  <= fs_sync;
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + 16'd1;
                    end
                end else begin
                    db_cnt <= '0;
                end
            end
        end
    end
    // level goal follows the state being entered so a step coinciding with a toggle uses the new target
    always_comb begin
        state_nxt = state;
`ifdef TREMOLO_CTRL_FADE_EN
        case (state)
            BYPASS:  state_nxt = toggle ? FADE_IN : BYPASS;
            FADE_IN: state_nxt = toggle ? FADE_OUT : (level_o == lvl_tgt) ? ACTIVE : FADE_IN;
            ACTIVE:  state_nxt = toggle ? FADE_OUT : ACTIVE;
            default: state_nxt = toggle ? FADE_IN : (level_o == 8'd0) ? BYPASS : FADE_OUT;
        endcase
        lvl_goal = (state_nxt == FADE_IN || state_nxt == ACTIVE) ? lvl_tgt : 8'd0;
`else
        state_nxt = toggle ? ((state == BYPASS) ? ACTIVE : BYPASS) : state;
        lvl_goal  = lvl_tgt;
`endif
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state              <= BYPASS;
            enable_o           <= 1'b0;
            div                <= '0;
            lvl_tgt            <= '0;
            frq_tgt            <= '0;
            level_o            <= '0;
            frequency_number_o <= '0;
        end else begin
            state <= state_nxt;
`ifdef TREMOLO_CTRL_FADE_EN
            // enable lags the state by a clock; the fade starts from level 0 so this is click-free
            enable_o <= (state != BYPASS);
`else
            enable_o <= (state_nxt == ACTIVE);
`endif
            if (sample_tick_i) begin
                div     <= slew_ev ? 8'd0 : div + 8'd1;
                lvl_tgt <= level_raw_i;
                frq_tgt <= frequency_raw_i;
                if (slew_ev) begin
                    level_o            <= step_toward(level_o, lvl_goal);
                    frequency_number_o <= step_toward(frequency_number_o, frq_tgt);
                end
            end
        end
    end
endmodule

// File: tb/tb_tremolo_ctrl.sv
// tb_tremolo_ctrl: directed bench for tremolo_ctrl with DEBOUNCE_TICKS=4, SLEW_DIV=2
module tb_tremolo_ctrl;
    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       sample_tick_i = 1'b0;
    logic       footswitch_i = 1'b0;
    logic [7:0] level_raw_i = '0;
    logic [7:0] frequency_raw_i = '0;
    logic       enable_o;
    logic [7:0] level_o;
    logic [7:0] frequency_number_o;
    int         checks = 0;
    int         errors = 0;
    tremolo_ctrl #(.DEBOUNCE_TICKS(4), .SLEW_DIV(2)) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .sample_tick_i      (sample_tick_i),
        .footswitch_i       (footswitch_i),
        .level_raw_i        (level_raw_i),
        .frequency_raw_i    (frequency_raw_i),
        .enable_o           (enable_o),
        .level_o            (level_o),
        .frequency_number_o (frequency_number_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sample_tick_i = 1'b1;
            cyc();
            sample_tick_i = 1'b0;
            cyc();
        end
    endtask
    // set the footswitch and let it clear the synchronizer before the next tick
    task automatic fs(input logic v);
        footswitch_i = v;
        cyc();
        cyc();
    endtask
    initial begin
        cyc();
        cyc();
        check("rst_enable", enable_o, 0);
        check("rst_level", level_o, 0);
        check("rst_freq", frequency_number_o, 0);
        #2 rstn_i = 1'b1;
        cyc();
        level_raw_i = 8'd10;
        frequency_raw_i = 8'd3;
`ifdef TREMOLO_CTRL_FADE_EN
        ticks(6);
        check("freq_reach3", frequency_number_o, 3);
        check("bypass_level_hold", level_o, 0);
        check("bypass_enable", enable_o, 0);
        fs(1'b1);
        ticks(4);
        check("enable_lags_state", enable_o, 0);
        ticks(1);
        check("fade_in_enable", enable_o, 1);
        check("fade_in_start", level_o, 0);
        ticks(18);
        check("fade_in_9", level_o, 9);
        ticks(1);
        check("fade_in_10", level_o, 10);
        fs(1'b0);
        ticks(4);
        check("release_enable", enable_o, 1);
        check("release_level", level_o, 10);
        fs(1'b1);
        ticks(4);
        ticks(19);
        check("fade_out_1", level_o, 1);
        check("fade_out_enable", enable_o, 1);
        ticks(1);
        check("fade_out_0", level_o, 0);
        check("fade_out_enable_hold", enable_o, 1);
        ticks(1);
        check("bypass_after_fade", enable_o, 0);
        fs(1'b0);
        ticks(4);
        fs(1'b1);
        ticks(4);
        ticks(19);
        check("refade_in_10", level_o, 10);
        fs(1'b0);
        ticks(4);
        fs(1'b1);
        ticks(4);
        fs(1'b0);
        ticks(4);
        check("fade_out_8", level_o, 8);
        ticks(4);
        fs(1'b1);
        ticks(4);
        check("fade_out_4", level_o, 4);
        check("reverse_enable", enable_o, 1);
        ticks(2);
        check("reverse_rise_5", level_o, 5);
        ticks(10);
        check("reverse_rise_10", level_o, 10);
        ticks(1);
        check("active_enable", enable_o, 1);
        check("active_level", level_o, 10);
        fs(1'b0);
        ticks(4);
        fs(1'b1);
        ticks(4);
        ticks(5);
        check("pre_reset_level7", level_o, 7);
        #2 rstn_i = 1'b0;
        #1;
        check("async_rst_enable", enable_o, 0);
        check("async_rst_level", level_o, 0);
        check("async_rst_freq", frequency_number_o, 0);
        footswitch_i = 1'b0;
        cyc();
        #2 rstn_i = 1'b1;
        cyc();
        ticks(10);
        check("post_rst_bypass_en", enable_o, 0);
        check("post_rst_bypass_lvl", level_o, 0);
`else
        ticks(5);
        check("freq_2", frequency_number_o, 2);
        ticks(1);
        check("freq_3", frequency_number_o, 3);
        ticks(13);
        check("level_9", level_o, 9);
        ticks(1);
        check("level_10", level_o, 10);
        check("enable_idle", enable_o, 0);
        fs(1'b1);
        ticks(3);
        fs(1'b0);
        ticks(2);
        fs(1'b1);
        ticks(3);
        fs(1'b0);
        ticks(2);
        check("bounce_no_toggle", enable_o, 0);
        fs(1'b1);
        ticks(3);
        check("hold3_no_toggle", enable_o, 0);
        sample_tick_i = 1'b1;
        cyc();
        check("toggle_cycle_en", enable_o, 0);
        sample_tick_i = 1'b0;
        cyc();
        check("enable_after_toggle", enable_o, 1);
        check("level_unaffected", level_o, 10);
        fs(1'b0);
        ticks(10);
        check("release_no_toggle", enable_o, 1);
        check("release_level", level_o, 10);
        level_raw_i = 8'd255;
        frequency_raw_i = 8'd255;
        ticks(489);
        check("level_254", level_o, 254);
        ticks(1);
        check("level_255", level_o, 255);
        ticks(26);
        check("level_255_hold", level_o, 255);
        check("freq_255_hold", frequency_number_o, 255);
        level_raw_i = 8'd0;
        frequency_raw_i = 8'd0;
        ticks(509);
        check("level_down_1", level_o, 1);
        ticks(1);
        check("level_down_0", level_o, 0);
        ticks(10);
        check("level_0_hold", level_o, 0);
        check("freq_0_hold", frequency_number_o, 0);
        check("enable_kept", enable_o, 1);
        level_raw_i = 8'd50;
        ticks(20);
        check("pre_reset_level10", level_o, 10);
        #2 rstn_i = 1'b0;
        #1;
        check("async_rst_enable", enable_o, 0);
        check("async_rst_level", level_o, 0);
        check("async_rst_freq", frequency_number_o, 0);
        #2 rstn_i = 1'b1;
        ticks(4);
        check("post_rst_enable", enable_o, 0);
        check("post_rst_level", level_o, 2);
        fs(1'b1);
        ticks(4);
        check("post_rst_press", enable_o, 1);
        check("post_rst_level4", level_o, 4);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
